vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised single-clock successor to the display controller. It generates HS/VS/BLANK for any raster set by parameters, with selectable sync polarity. It issues pixel requests a configurable number of cycles ahead of display so SDRAM/line-buffer readers with fixed latency stay aligned. It also adds frame/line strobes, an incrementing frame-buffer address (no multiplier) and built-in test patterns. It sits between the frame-buffer read port and the VGA DAC pins.

Parameters:
H_ACT, 800, active pixels per line
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width
H_BACK, 88, horizontal back porch
V_ACT, 600, active lines
V_FRONT, 2, vertical front porch (lines)
V_SYNC, 4, vertical sync width
V_BACK, 21, vertical back porch
HS_POL, 1, HS asserted level (1 = positive pulse)
VS_POL, 1, VS asserted level
REQ_LEAD, 2, host read latency in cycles (1..8): data arrives REQ_LEAD cycles after oRequest
COLOR_W, 10, bits per colour channel
ADDR_W, 22, address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT

Ports:
iCLK  in  1  pixel clock
iRST  in  1  asynchronous active-high reset
iMode  in  2  0 = host pixels, 1 = 8 colour bars, 2 = 16-px white grid on black, 3 = solid black
iRed/iGreen/iBlue  in  COLOR_W each  host pixel, valid exactly REQ_LEAD cycles after its oRequest
oRequest  out  1  fetch pixel at (oCurrent_X, oCurrent_Y, oAddress) this cycle
oCurrent_X  out  12  fetch-side column (0 outside active)
oCurrent_Y  out  12  fetch-side line (0 outside active)
oAddress  out  ADDR_W  linear frame-buffer address of requested pixel
oFrame_Start  out  1  one-cycle pulse with request of pixel (0,0)
oLine_Start  out  1  one-cycle pulse with request of pixel (0,y), every active line
oVGA_R/oVGA_G/oVGA_B  out  COLOR_W each  DAC colour
oVGA_HS, oVGA_VS  out  1  sync outputs, polarity per HS_POL/VS_POL
oVGA_BLANK  out  1  low during blanking
oVGA_SYNC  out  1  constant 1

Behaviour:
- Single clock domain. V counter advances on iCLK when H_Cont wraps; no HS-derived clock.
- H_Cont 0..H_TOTAL-1, H_TOTAL = H_ACT+H_FRONT+H_SYNC+H_BACK. Order: active [0,H_ACT), front porch, sync, back porch. V_Cont follows the same order in lines.
- Wrap: H_Cont==H_TOTAL-1 -> 0 and V_Cont increments. V_Cont==V_TOTAL-1 at the same time -> 0.
- Fetch side, combinational from counters:
  - active = H_Cont<H_ACT && V_Cont<V_ACT; oRequest = active.
  - oCurrent_X/Y = counters when active, else 0.
  - oFrame_Start = active && H==0 && V==0; oLine_Start = active && H==0.
- oAddress: registered counter. Cleared when the final active pixel of a frame is requested. Increments after each request, so it equals Y*H_ACT+X whenever oRequest=1.
- Display side: a delay line of REQ_LEAD+1 stages carries active, hs_raw, vs_raw and the pattern pixel.
  - hs_raw = H in sync region; vs_raw = V in sync region.
  - oVGA_HS = hs_raw_delayed ? HS_POL : ~HS_POL; VS likewise.
  - oVGA_BLANK = active_delayed.
  - RGB registered: mode 0 -> host data registered in the cycle it arrives; blank -> 0.
  - Net latency from oRequest to the DAC pixel is REQ_LEAD+1 cycles, identical for sync, blank and colour.
- Patterns are computed from fetch-side X/Y:
  - Bars: bar index 0..7 increments every H_ACT/8 pixels via a bar counter (no divider). RGB = {idx[2]?max:0, idx[1]?max:0, idx[0]?max:0}, with max = all ones.
  - Grid: white when X[3:0]==0 or Y[3:0]==0.
- iMode is sampled only on the cycle oFrame_Start=1. The latched mode applies from pixel (0,0) of that frame; mid-frame changes are ignored.
- Reset values:
  - H_Cont=V_Cont=0, oAddress=0, latched mode=0.
  - Delay line cleared; oVGA_HS=~HS_POL, oVGA_VS=~VS_POL, oVGA_BLANK=0, RGB=0.
- First cycle after reset release requests (0,0) with oFrame_Start=1.
- Reset asserted mid-frame forces reset values immediately; no partial-frame state survives.

Decomposition:
- Package vga_timing_pkg holds:
  - mode encodings (MODE_HOST, MODE_BARS, MODE_GRID, MODE_BLACK);
  - 640x480p60 and 800x600p60 timing constant sets.
- One sub-module, vga_delay_line (parametrised depth and width, async-reset shift register), used for the sync/blank/pattern alignment.

Test Plan:
Use a small raster: H_ACT=8, FRONT=2, SYNC=3, BACK=2 (H_TOTAL=15); V_ACT=4, FRONT=1, SYNC=2, BACK=1 (V_TOTAL=8); REQ_LEAD=2, HS_POL=VS_POL=0.
- Free run 2 frames -> oRequest high 8 of every 15 cycles on lines 0-3 only. oFrame_Start every 120 cycles. oAddress sequences 0..31 then 0.
- Sync timing -> oVGA_HS low for 3 cycles starting 3+10=13 cycles after the oLine_Start edge. oVGA_VS low for 2 lines starting at line 5 (+3-cycle offset).
- Mode 0 with a host model returning R=address 2 cycles after request -> oVGA_R=0..31 in order, each 3 cycles after its request; 0 during blanking.
- Mode 1 (bar width 1) -> row pixels RGB = 000,001,...,111 (0/1023 per channel).
- iMode 0->2 mid-frame -> output unchanged until next oFrame_Start. Then grid: pixel (0,y) white, and since X[3:0]==0 only at X=0, row 0 fully white.
- iRST pulse at H=5,V=2 -> outputs take reset values asynchronously. After release, oFrame_Start=1 and oAddress=0 on the first clock.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared definitions for the VGA timing generator.
//               - Output mode encodings.
//               - Standard raster timing sets for 640x480p60 and 800x600p60.
//               - Bar-width helper so the colour-bar counter needs no divider.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

   // Output mode, sampled at the start of each frame
   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOST  = 2'd0;   // pixels from the frame-buffer port
   localparam mode_t MODE_BARS  = 2'd1;   // eight vertical colour bars
   localparam mode_t MODE_GRID  = 2'd2;   // 16-pixel white grid on black
   localparam mode_t MODE_BLACK = 2'd3;   // solid black

   // One raster axis: active, front porch, sync, back porch
   typedef struct packed {
      logic [11:0] act;
      logic [11:0] front;
      logic [11:0] sync;
      logic [11:0] back;
   } axis_timing_t;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam axis_timing_t VGA640_H = '{act: 12'd640, front: 12'd16, sync: 12'd96,  back: 12'd48};
   localparam axis_timing_t VGA640_V = '{act: 12'd480, front: 12'd10, sync: 12'd2,   back: 12'd33};

   // 800x600 @ 60 Hz, 40 MHz pixel clock
   localparam axis_timing_t VGA800_H = '{act: 12'd800, front: 12'd40, sync: 12'd128, back: 12'd88};
   localparam axis_timing_t VGA800_V = '{act: 12'd600, front: 12'd1,  sync: 12'd4,   back: 12'd23};

   // Width of one colour bar in pixels; never zero, even for tiny rasters
   function automatic int unsigned bar_width(input int unsigned h_act);
      return (h_act / 8 == 0) ? 1 : h_act / 8;
   endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Fixed-depth shift register with asynchronous active-high
//               reset; every stage clears to zero.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               din  - WIDTH-bit input sample
//               dout - din delayed by DEPTH clock cycles
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Stage 0 occupies the least significant WIDTH bits
   logic [DEPTH*WIDTH-1:0] pipe;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pipe <= '0;
            end else begin
               pipe <= din;
            end
         end
      end else begin : g_multi
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pipe <= '0;
            end else begin
               pipe <= {pipe[(DEPTH-1)*WIDTH-1:0], din};
            end
         end
      end
   endgenerate

   assign dout = pipe[DEPTH*WIDTH-1 -: WIDTH];

endmodule : vga_delay_line
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised single-clock VGA raster generator. Issues pixel
//               requests REQ_LEAD cycles ahead of display, keeps a linear
//               frame-buffer address, provides frame/line strobes and built-in
//               test patterns, and drives sync/blank/RGB to the DAC with an
//               identical REQ_LEAD+1 cycle latency on every output.
// Ports       : iCLK, iRST              - pixel clock, async active-high reset
//               iMode                   - output mode, sampled at frame start
//               iRed/iGreen/iBlue       - host pixel, REQ_LEAD after request
//               oRequest, oCurrent_X/Y  - fetch-side request and position
//               oAddress                - linear address of requested pixel
//               oFrame_Start/oLine_Start- strobes with pixel (0,0) / (0,y)
//               oVGA_R/G/B              - DAC colour
//               oVGA_HS/VS/BLANK/SYNC   - DAC control pins
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACT    = 800,
   parameter int H_FRONT  = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int V_ACT    = 600,
   parameter int V_FRONT  = 2,
   parameter int V_SYNC   = 4,
   parameter int V_BACK   = 21,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1,
   parameter int REQ_LEAD = 2,
   parameter int COLOR_W  = 10,
   parameter int ADDR_W   = 22
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [1:0]         iMode,
   input  logic [COLOR_W-1:0] iRed,
   input  logic [COLOR_W-1:0] iGreen,
   input  logic [COLOR_W-1:0] iBlue,
   output logic               oRequest,
   output logic [11:0]        oCurrent_X,
   output logic [11:0]        oCurrent_Y,
   output logic [ADDR_W-1:0]  oAddress,
   output logic               oFrame_Start,
   output logic               oLine_Start,
   output logic [COLOR_W-1:0] oVGA_R,
   output logic [COLOR_W-1:0] oVGA_G,
   output logic [COLOR_W-1:0] oVGA_B,
   output logic               oVGA_HS,
   output logic               oVGA_VS,
   output logic               oVGA_BLANK,
   output logic               oVGA_SYNC
);

   // ------------------------------------------------------------------------
   // Raster constants
   // ------------------------------------------------------------------------
   localparam logic [11:0] H_ACT_LAST = 12'(H_ACT - 1);
   localparam logic [11:0] H_LAST     = 12'(H_ACT + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [11:0] H_SYNC_BEG = 12'(H_ACT + H_FRONT);
   localparam logic [11:0] H_SYNC_END = 12'(H_ACT + H_FRONT + H_SYNC);
   localparam logic [11:0] V_ACT_LAST = 12'(V_ACT - 1);
   localparam logic [11:0] V_LAST     = 12'(V_ACT + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [11:0] V_SYNC_BEG = 12'(V_ACT + V_FRONT);
   localparam logic [11:0] V_SYNC_END = 12'(V_ACT + V_FRONT + V_SYNC);
   localparam logic [11:0] H_ACT_W    = 12'(H_ACT);
   localparam logic [11:0] V_ACT_W    = 12'(V_ACT);
   localparam logic [11:0] BAR_LAST   = 12'(bar_width(H_ACT) - 1);

   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);

   // Delay-line payload: active, hs, vs, host-select, pattern RGB
   localparam int PAY_W = 4 + 3 * COLOR_W;

   // ------------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------------
   logic [11:0] h_cont;
   logic [11:0] v_cont;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         h_cont <= '0;
         v_cont <= '0;
      end else if (h_cont == H_LAST) begin
         h_cont <= '0;
         if (v_cont == V_LAST) begin
            v_cont <= '0;
         end else begin
            v_cont <= v_cont + 12'd1;
         end
      end else begin
         h_cont <= h_cont + 12'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Fetch side (combinational from the counters)
   // ------------------------------------------------------------------------
   logic active;
   logic hs_raw;
   logic vs_raw;
   logic frame_start;

   assign active      = (h_cont < H_ACT_W) && (v_cont < V_ACT_W);
   assign hs_raw      = (h_cont >= H_SYNC_BEG) && (h_cont < H_SYNC_END);
   assign vs_raw      = (v_cont >= V_SYNC_BEG) && (v_cont < V_SYNC_END);
   assign frame_start = active && (h_cont == 12'd0) && (v_cont == 12'd0);

   assign oRequest     = active;
   assign oCurrent_X   = active ? h_cont : 12'd0;
   assign oCurrent_Y   = active ? v_cont : 12'd0;
   assign oFrame_Start = frame_start;
   assign oLine_Start  = active && (h_cont == 12'd0);
   assign oVGA_SYNC    = 1'b1;

   // ------------------------------------------------------------------------
   // Linear frame-buffer address: advances once per request and returns to
   // zero after the last active pixel, so it always equals Y*H_ACT+X while
   // oRequest is high without needing a multiplier.
   // ------------------------------------------------------------------------
   logic [ADDR_W-1:0] addr;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         addr <= '0;
      end else if (active) begin
         if ((h_cont == H_ACT_LAST) && (v_cont == V_ACT_LAST)) begin
            addr <= '0;
         end else begin
            addr <= addr + ADDR_W'(1);
         end
      end
   end

   assign oAddress = addr;

   // ------------------------------------------------------------------------
   // Mode latch. On the frame-start cycle the incoming mode is used directly
   // so that pixel (0,0) already follows the newly sampled mode.
   // ------------------------------------------------------------------------
   mode_t mode_q;
   mode_t eff_mode;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         mode_q <= MODE_HOST;
      end else if (frame_start) begin
         mode_q <= iMode;
      end
   end

   assign eff_mode = frame_start ? iMode : mode_q;

   // ------------------------------------------------------------------------
   // Colour-bar tracker. bar_idx is the bar of the pixel currently being
   // requested; it restarts on the last active pixel of every line so the
   // next line begins at bar 0. The index saturates at 7 when H_ACT is not
   // a multiple of eight.
   // ------------------------------------------------------------------------
   logic [11:0] bar_pix;
   logic [2:0]  bar_idx;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         bar_pix <= '0;
         bar_idx <= '0;
      end else if (active) begin
         if (h_cont == H_ACT_LAST) begin
            bar_pix <= '0;
            bar_idx <= '0;
         end else if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            if (bar_idx != 3'd7) begin
               bar_idx <= bar_idx + 3'd1;
            end
         end else begin
            bar_pix <= bar_pix + 12'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Pattern pixel for the pixel being requested this cycle
   // ------------------------------------------------------------------------
   localparam logic [COLOR_W-1:0] C_MAX = '1;

   logic [COLOR_W-1:0] pat_r;
   logic [COLOR_W-1:0] pat_g;
   logic [COLOR_W-1:0] pat_b;
   logic               use_host;

   always_comb begin
      pat_r    = '0;
      pat_g    = '0;
      pat_b    = '0;
      use_host = 1'b0;
      case (eff_mode)
         MODE_HOST: begin
            use_host = 1'b1;
         end
         MODE_BARS: begin
            pat_r = bar_idx[2] ? C_MAX : '0;
            pat_g = bar_idx[1] ? C_MAX : '0;
            pat_b = bar_idx[0] ? C_MAX : '0;
         end
         MODE_GRID: begin
            if ((oCurrent_X[3:0] == 4'd0) || (oCurrent_Y[3:0] == 4'd0)) begin
               pat_r = C_MAX;
               pat_g = C_MAX;
               pat_b = C_MAX;
            end
         end
         default: begin
            // solid black: all channels stay zero
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Alignment: REQ_LEAD stages bring the fetch-side state level with the
   // host data; the output register below adds the final stage so every
   // DAC pin lags its request by REQ_LEAD+1 cycles.
   // ------------------------------------------------------------------------
   logic [PAY_W-1:0] pay_in;
   logic [PAY_W-1:0] pay_out;

   assign pay_in = {active, hs_raw, vs_raw, use_host, pat_r, pat_g, pat_b};

   vga_delay_line #(
      .DEPTH (REQ_LEAD),
      .WIDTH (PAY_W)
   ) u_align (
      .clk  (iCLK),
      .rst  (iRST),
      .din  (pay_in),
      .dout (pay_out)
   );

   logic               d_active;
   logic               d_hs;
   logic               d_vs;
   logic               d_host;
   logic [COLOR_W-1:0] d_r;
   logic [COLOR_W-1:0] d_g;
   logic [COLOR_W-1:0] d_b;

   assign {d_active, d_hs, d_vs, d_host, d_r, d_g, d_b} = pay_out;

   // ------------------------------------------------------------------------
   // DAC output register
   // ------------------------------------------------------------------------
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oVGA_HS    <= ~HS_ON;
         oVGA_VS    <= ~VS_ON;
         oVGA_BLANK <= 1'b0;
         oVGA_R     <= '0;
         oVGA_G     <= '0;
         oVGA_B     <= '0;
      end else begin
         oVGA_HS    <= d_hs ? HS_ON : ~HS_ON;
         oVGA_VS    <= d_vs ? VS_ON : ~VS_ON;
         oVGA_BLANK <= d_active;
         if (!d_active) begin
            oVGA_R <= '0;
            oVGA_G <= '0;
            oVGA_B <= '0;
         end else if (d_host) begin
            oVGA_R <= iRed;
            oVGA_G <= iGreen;
            oVGA_B <= iBlue;
         end else begin
            oVGA_R <= d_r;
            oVGA_G <= d_g;
            oVGA_B <= d_b;
         end
      end
   end

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen on a 15x8 raster.
//               The reference derives every expected output from the cycle
//               number since reset release (h = t mod 15, v = t/15 mod 8),
//               with random host pixels and random mode changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   localparam int H_ACT    = 8;
   localparam int H_FRONT  = 2;
   localparam int H_SYNC   = 3;
   localparam int H_BACK   = 2;
   localparam int V_ACT    = 4;
   localparam int V_FRONT  = 1;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 1;
   localparam int REQ_LEAD = 2;
   localparam int CW       = 10;
   localparam int AW       = 5;
   localparam int H_TOT    = H_ACT + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT    = V_ACT + V_FRONT + V_SYNC + V_BACK;
   localparam int LAT      = REQ_LEAD + 1;
   localparam int FRAME    = H_TOT * V_TOT;
   localparam logic [CW-1:0] MAXC = '1;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic [CW-1:0] red, green, blue;
   logic          request, frame_start, line_start;
   logic [11:0]   cur_x, cur_y;
   logic [AW-1:0] address;
   logic [CW-1:0] vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs, vga_blank, vga_sync;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACT (H_ACT), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
      .V_ACT (V_ACT), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
      .HS_POL (0), .VS_POL (0), .REQ_LEAD (REQ_LEAD), .COLOR_W (CW), .ADDR_W (AW)
   ) dut (
      .iCLK         (clk),
      .iRST         (rst),
      .iMode        (mode),
      .iRed         (red),
      .iGreen       (green),
      .iBlue        (blue),
      .oRequest     (request),
      .oCurrent_X   (cur_x),
      .oCurrent_Y   (cur_y),
      .oAddress     (address),
      .oFrame_Start (frame_start),
      .oLine_Start  (line_start),
      .oVGA_R       (vga_r),
      .oVGA_G       (vga_g),
      .oVGA_B       (vga_b),
      .oVGA_HS      (vga_hs),
      .oVGA_VS      (vga_vs),
      .oVGA_BLANK   (vga_blank),
      .oVGA_SYNC    (vga_sync)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int t        = 0;
   int frame_no = 0;
   logic [1:0] frame_mode = 2'd0;
   logic [1:0] mode_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};

   // Reference records per fetch cycle
   bit          rec_act [1024];
   bit          rec_hs  [1024];
   bit          rec_vs  [1024];
   logic [29:0] rec_rgb [1024];
   logic [29:0] host_rgb[1024];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Model, drive and check one pixel-clock cycle t
   task automatic do_cycle();
      int h, v, x, y;
      bit act;
      logic [29:0] exp_rgb;
      logic ehs, evs, eblank;
      logic [29:0] eout;

      h   = t % H_TOT;
      v   = (t / H_TOT) % V_TOT;
      act = (h < H_ACT) && (v < V_ACT);
      x   = act ? h : 0;
      y   = act ? v : 0;

      // Mode: forced at frame start, random noise mid-frame (must be ignored)
      if (h == 0 && v == 0) begin
         mode       = mode_seq[frame_no % 6];
         frame_mode = mode;
         frame_no++;
      end else if ($urandom_range(0, 19) == 0) begin
         mode = 2'($urandom_range(0, 3));
      end

      // Host model: random pixel per request, presented REQ_LEAD cycles later
      host_rgb[t] = act ? 30'($urandom) : 30'd0;
      if (t >= REQ_LEAD && rec_act[t-REQ_LEAD]) begin
         {red, green, blue} = host_rgb[t-REQ_LEAD];
      end else begin
         {red, green, blue} = 30'($urandom);
      end

      rec_act[t] = act;
      rec_hs[t]  = (h >= H_ACT + H_FRONT) && (h < H_ACT + H_FRONT + H_SYNC);
      rec_vs[t]  = (v >= V_ACT + V_FRONT) && (v < V_ACT + V_FRONT + V_SYNC);
      if (!act) begin
         exp_rgb = '0;
      end else begin
         case (frame_mode)
            2'd0:    exp_rgb = host_rgb[t];
            2'd1:    exp_rgb = {(((x >> 2) & 1) != 0) ? MAXC : 10'd0,
                                (((x >> 1) & 1) != 0) ? MAXC : 10'd0,
                                ((x & 1) != 0)        ? MAXC : 10'd0};
            2'd2:    exp_rgb = ((x % 16 == 0) || (y % 16 == 0)) ? {MAXC, MAXC, MAXC} : 30'd0;
            default: exp_rgb = '0;
         endcase
      end
      rec_rgb[t] = exp_rgb;

      // Fetch side
      check_val("request", request, act);
      check_val("cur_x", cur_x, x);
      check_val("cur_y", cur_y, y);
      check_val("frame_start", frame_start, act && h == 0 && v == 0);
      check_val("line_start", line_start, act && h == 0);
      if (act) check_val("address", address, v * H_ACT + h);

      // Display side lags the fetch side by LAT cycles
      if (t >= LAT) begin
         ehs    = rec_hs[t-LAT] ? 1'b0 : 1'b1;
         evs    = rec_vs[t-LAT] ? 1'b0 : 1'b1;
         eblank = rec_act[t-LAT];
         eout   = rec_rgb[t-LAT];
      end else begin
         ehs    = 1'b1;
         evs    = 1'b1;
         eblank = 1'b0;
         eout   = '0;
      end
      check_val("hs", vga_hs, ehs);
      check_val("vs", vga_vs, evs);
      check_val("blank", vga_blank, eblank);
      check_val("rgb", {vga_r, vga_g, vga_b}, eout);
      check_val("sync", vga_sync, 1'b1);
   endtask

   initial begin
      rst   = 1'b1;
      mode  = 2'd0;
      red   = '0;
      green = '0;
      blue  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_hs", vga_hs, 1'b1);
      check_val("rst_vs", vga_vs, 1'b1);
      check_val("rst_blank", vga_blank, 1'b0);
      check_val("rst_rgb", {vga_r, vga_g, vga_b}, 30'd0);
      check_val("rst_addr", address, 0);

      @(negedge clk);
      rst = 1'b0;
      t   = 0;
      do_cycle();
      // Run to pixel H=5, V=2 of the fifth frame
      while (t < 4 * FRAME + 2 * H_TOT + 5) begin
         @(posedge clk);
         #1;
         t++;
         do_cycle();
      end

      // Asynchronous reset mid-frame: outputs must respond before any edge
      #2 rst = 1'b1;
      #1;
      check_val("arst_blank", vga_blank, 1'b0);
      check_val("arst_hs", vga_hs, 1'b1);
      check_val("arst_vs", vga_vs, 1'b1);
      check_val("arst_rgb", {vga_r, vga_g, vga_b}, 30'd0);
      check_val("arst_addr", address, 0);
      check_val("arst_frame_start", frame_start, 1'b1);
      check_val("arst_x", cur_x, 0);
      check_val("arst_y", cur_y, 0);
      @(posedge clk);
      #1;
      check_val("arst_hold_addr", address, 0);

      @(negedge clk);
      rst = 1'b0;
      t   = 0;
      do_cycle();
      repeat (2 * FRAME + 10) begin
         @(posedge clk);
         #1;
         t++;
         do_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_vga_timing_gen
`default_nettype wire
